// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants for the instruction loader: op codes, RV32 opcode/funct
// fields and the terminating NOP word.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRA  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9,
        OP_MAC  = 4'd10
    } op_e;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_L   = 7'b0000011;
    localparam logic [6:0] OPC_S   = 7'b0100011;
    localparam logic [6:0] OPC_B   = 7'b1100011;
    localparam logic [6:0] OPC_MAC = 7'b1111111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_LW_SW   = 3'b010;
    localparam logic [2:0] F3_SRA     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    function automatic logic [31:0] r_word(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_encode.sv
// Combinational encoder: one symbolic request to one 32-bit instruction word.
// Unsupported op codes produce a zero word and raise illegal_o.
module instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_e'(op_i))
            OP_ADD:  word_o = r_word(F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_R);
            OP_SUB:  word_o = r_word(F7_ALT,  rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_R);
            OP_AND:  word_o = r_word(F7_BASE, rs2_i, rs1_i, F3_AND,     rd_i, OPC_R);
            OP_OR:   word_o = r_word(F7_BASE, rs2_i, rs1_i, F3_OR,      rd_i, OPC_R);
            OP_SLL:  word_o = r_word(F7_BASE, rs2_i, rs1_i, F3_SLL,     rd_i, OPC_R);
            OP_SRA:  word_o = r_word(F7_ALT,  rs2_i, rs1_i, F3_SRA,     rd_i, OPC_R);
            OP_ADDI: word_o = {imm_i[11:0], rs1_i, F3_ADD_SUB, rd_i, OPC_I};
            OP_LW:   word_o = {imm_i[11:0], rs1_i, F3_LW_SW, rd_i, OPC_L};
            OP_SW:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_LW_SW, imm_i[4:0], OPC_S};
            // Branch offset is in bytes; bit 0 is implicitly zero and not encoded.
            OP_BEQ:  word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_ADD_SUB,
                               imm_i[4:1], imm_i[11], OPC_B};
            OP_MAC:  word_o = r_word(F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OPC_MAC);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loader FSM: encodes accepted requests into sequential instruction-memory writes,
// appends a NOP on load_end, then reports program length and pulses core_start.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   prog_len,
    output logic              core_start,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_TERM, S_DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, we_q, start_q, err_ill_q, err_ovf_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q, enc_word;
    logic [CNT_W-1:0]   prog_len_q;
    logic               enc_illegal, accept, write_req;

    instr_encode u_encode (
        .op_i      (req_op),
        .rd_i      (req_rd),
        .rs1_i     (req_rs1),
        .rs2_i     (req_rs2),
        .imm_i     (req_imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign accept    = (state_q == S_LOAD) && req_valid && ready_q;
    assign write_req = accept && !enc_illegal;
    assign count_d   = write_req ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            prog_len_q <= '0;
            start_q    <= 1'b0;
            err_ill_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state_q    <= S_LOAD;
                        count_q    <= '0;
                        ready_q    <= 1'b1;
                        prog_len_q <= '0;
                        err_ill_q  <= 1'b0;
                        err_ovf_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (write_req) begin
                        we_q    <= 1'b1;
                        addr_q  <= count_q[ADDR_W-1:0];
                        wdata_q <= enc_word;
                        count_q <= count_d;
                    end
                    if (accept && enc_illegal) err_ill_q <= 1'b1;
                    if (req_valid && count_q == LAST) err_ovf_q <= 1'b1;
                    // Ready tracks the post-update count so it stays purely registered.
                    ready_q <= !load_end && (count_d < LAST);
                    if (load_end) state_q <= S_TERM;
                end
                S_TERM: begin
                    we_q       <= 1'b1;
                    addr_q     <= count_q[ADDR_W-1:0];
                    wdata_q    <= NOP_WORD;
                    count_q    <= count_q + 1'b1;
                    prog_len_q <= count_q + 1'b1;
                    start_q    <= 1'b1;
                    state_q    <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign prog_len     = prog_len_q;
    assign core_start   = start_q;
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: a default-depth loader and a DEPTH=4 loader for overflow behaviour.
module tb_instr_encoder_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // main DUT signals
    logic        m_ls = 0, m_le = 0, m_valid = 0;
    logic [3:0]  m_op = '0;
    logic [4:0]  m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    logic [12:0] m_imm = '0;
    logic        m_ready, m_we, m_cs, m_eill, m_eovf;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [8:0]  m_plen;

    // small DUT signals
    logic        s_ls = 0, s_le = 0, s_valid = 0;
    logic [12:0] s_imm = '0;
    logic        s_ready, s_we, s_cs, s_eill, s_eovf;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic [8:0]  s_plen;

    exp_t q_main[$];
    exp_t q_small[$];
    exp_t me, se;
    int   m_model = 0;
    int   m_cs_cnt = 0, s_cs_cnt = 0;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) u_dut (
        .clk(clk), .rst(rst), .load_start(m_ls), .load_end(m_le),
        .req_valid(m_valid), .req_ready(m_ready), .req_op(m_op),
        .req_rd(m_rd), .req_rs1(m_rs1), .req_rs2(m_rs2), .req_imm(m_imm),
        .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
        .prog_len(m_plen), .core_start(m_cs),
        .err_illegal(m_eill), .err_overflow(m_eovf)
    );

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .load_start(s_ls), .load_end(s_le),
        .req_valid(s_valid), .req_ready(s_ready), .req_op(4'd6),
        .req_rd(5'd1), .req_rs1(5'd0), .req_rs2(5'd0), .req_imm(s_imm),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .prog_len(s_plen), .core_start(s_cs),
        .err_illegal(s_eill), .err_overflow(s_eovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Write monitors: every imem write must match the oldest expected entry.
    always @(negedge clk) begin
        if (m_cs) m_cs_cnt++;
        if (s_cs) s_cs_cnt++;
        if (m_we === 1'b1) begin
            if (q_main.size() == 0) begin
                chk_cnt++;
                $display("FAIL main_unexpected_write: got addr %0d data %h expected no write", m_addr, m_wdata);
            end else begin
                me = q_main.pop_front();
                chk("main_addr", 32'(m_addr), 32'(me.addr));
                chk("main_data", m_wdata, me.data);
            end
        end
        if (s_we === 1'b1) begin
            if (q_small.size() == 0) begin
                chk_cnt++;
                $display("FAIL small_unexpected_write: got addr %0d data %h expected no write", s_addr, s_wdata);
            end else begin
                se = q_small.pop_front();
                chk("small_addr", 32'(s_addr), 32'(se.addr));
                chk("small_data", s_wdata, se.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_start();
        m_ls = 1'b1;
        step();
        m_ls = 1'b0;
        m_model = 0;
        chk("main_ready_after_start", 32'(m_ready), 32'd1);
    endtask

    task automatic m_push(input logic [31:0] word);
        q_main.push_back('{addr: 8'(m_model), data: word});
        m_model++;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm,
                        input bit legal, input logic [31:0] word, input bit with_end);
        if (legal) m_push(word);
        if (with_end) m_push(32'h0000_0013);
        m_op = op; m_rd = rd; m_rs1 = rs1; m_rs2 = rs2; m_imm = imm;
        m_valid = 1'b1;
        m_le = with_end;
        step();
        m_valid = 1'b0;
        m_le = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},    32'(m_ready), 32'd0);
        chk({tag, "_we"},       32'(m_we),    32'd0);
        chk({tag, "_addr"},     32'(m_addr),  32'd0);
        chk({tag, "_wdata"},    m_wdata,      32'd0);
        chk({tag, "_prog_len"}, 32'(m_plen),  32'd0);
        chk({tag, "_start"},    32'(m_cs),    32'd0);
        chk({tag, "_err_ill"},  32'(m_eill),  32'd0);
        chk({tag, "_err_ovf"},  32'(m_eovf),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        chk_reset_vals("reset");
        chk("small_reset_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        step();

        // Session 1: every legal op, an illegal op, an ignored load_start, end with last accept
        m_start();
        send(4'd0,  5'd3, 5'd1, 5'd2, 13'd0,    1, 32'h002081B3, 0); // ADD
        send(4'd1,  5'd5, 5'd6, 5'd7, 13'd0,    1, 32'h407302B3, 0); // SUB
        send(4'd6,  5'd1, 5'd0, 5'd0, 13'd5,    1, 32'h00500093, 0); // ADDI
        send(4'd8,  5'd0, 5'd1, 5'd2, 13'd8,    1, 32'h0020A423, 0); // SW
        send(4'd9,  5'd0, 5'd1, 5'd2, 13'd8,    1, 32'h00208463, 0); // BEQ
        send(4'd10, 5'd4, 5'd1, 5'd2, 13'd0,    1, 32'h0020827F, 0); // MAC
        send(4'd2,  5'd3, 5'd1, 5'd2, 13'd0,    1, 32'h0020F1B3, 0); // AND
        send(4'd3,  5'd3, 5'd1, 5'd2, 13'd0,    1, 32'h0020E1B3, 0); // OR
        send(4'd4,  5'd3, 5'd1, 5'd2, 13'd0,    1, 32'h002091B3, 0); // SLL
        send(4'd5,  5'd3, 5'd1, 5'd2, 13'd0,    1, 32'h4020D1B3, 0); // SRA
        send(4'd7,  5'd1, 5'd2, 5'd0, 13'd4,    1, 32'h00412083, 0); // LW
        send(4'd6,  5'd2, 5'd2, 5'd0, 13'h1FFF, 1, 32'hFFF10113, 0); // ADDI -1
        send(4'd9,  5'd0, 5'd1, 5'd2, 13'h1FF8, 1, 32'hFE208CE3, 0); // BEQ -8
        send(4'd12, 5'd3, 5'd1, 5'd2, 13'd0,    0, 32'h0,        0); // illegal
        chk("err_illegal_set", 32'(m_eill), 32'd1);
        m_ls = 1'b1;
        step();
        m_ls = 1'b0;
        send(4'd0,  5'd3, 5'd1, 5'd2, 13'd0,    1, 32'h002081B3, 0); // lands at addr 13
        send(4'd10, 5'd4, 5'd1, 5'd2, 13'd0,    1, 32'h0020827F, 1); // with load_end
        step();
        chk("s1_core_start", 32'(m_cs), 32'd1);
        chk("s1_prog_len", 32'(m_plen), 32'd16);
        chk("s1_err_overflow", 32'(m_eovf), 32'd0);
        step();
        chk("s1_core_start_low", 32'(m_cs), 32'd0);
        chk("s1_start_pulses", 32'(m_cs_cnt), 32'd1);

        // Session 2: two ops, separate load_end
        m_start();
        chk("s2_err_illegal_cleared", 32'(m_eill), 32'd0);
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 32'h002081B3, 0);
        send(4'd6, 5'd1, 5'd0, 5'd0, 13'd5, 1, 32'h00500093, 0);
        m_push(32'h0000_0013);
        m_le = 1'b1;
        step();
        m_le = 1'b0;
        step();
        chk("s2_core_start", 32'(m_cs), 32'd1);
        chk("s2_prog_len", 32'(m_plen), 32'd3);
        step();
        chk("s2_start_pulses", 32'(m_cs_cnt), 32'd2);

        // Small DUT: requests held valid past the reserved NOP slot
        s_ls = 1'b1;
        step();
        s_ls = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q_small.push_back('{addr: 8'(i), data: 32'h00000093 | (32'(i) << 20)});
            s_imm = 13'(i);
            step();
        end
        s_imm = 13'd3;
        step();
        chk("small_ready_dropped", 32'(s_ready), 32'd0);
        chk("small_err_overflow", 32'(s_eovf), 32'd1);
        s_valid = 1'b0;
        q_small.push_back('{addr: 8'd3, data: 32'h0000_0013});
        s_le = 1'b1;
        step();
        s_le = 1'b0;
        step();
        chk("small_core_start", 32'(s_cs), 32'd1);
        chk("small_prog_len", 32'(s_plen), 32'd4);
        step();
        chk("small_start_pulses", 32'(s_cs_cnt), 32'd1);

        // Reset mid-session after two writes
        m_start();
        send(4'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1, 32'h002081B3, 0);
        send(4'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1, 32'h407302B3, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrst");
        m_le = 1'b1;
        step();
        m_le = 1'b0;
        repeat (5) step();
        chk("midrst_no_start", 32'(m_cs_cnt), 32'd2);
        chk("main_queue_drained", 32'(q_main.size()), 32'd0);
        chk("small_queue_drained", 32'(q_small.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Assembles symbolic operation requests into 32-bit instruction words and writes them sequentially into instruction memory before the core runs.
- It is the encode side of the decode step done at IF/ID. Every word it produces decodes there to exactly the requested control signals.
- At end of load it appends a terminating NOP, reports program length, and pulses core start.

## Interface
Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 256: usable words, ≤ 2^ADDR_W, ≥ 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- load_start  in  1  one-cycle pulse; begins a load session.
- load_end  in  1  one-cycle pulse; closes the session.
- req_valid  in  1  operation request valid.
- req_ready  out  1  encoder can accept a request.
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 MAC, 11–15 illegal.
- req_rd / req_rs1 / req_rs2  in  5 each  register indices.
- req_imm  in  13  signed immediate:
  - bits [11:0] are used by ADDI, LW and SW;
  - bits [12:1] are used by BEQ, which takes a byte offset with bit 0 ignored.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- prog_len  out  ADDR_W+1  words written including the NOP; valid in DONE.
- core_start  out  1  one-cycle pulse on entry to DONE.
- err_illegal  out  1  sticky: an illegal op was accepted.
- err_overflow  out  1  sticky: a request arrived while memory was full.

## Operation
States:
- IDLE
  - load_start → LOAD; clears the address counter and both error flags.
- LOAD
  - req_ready = 1 while count < DEPTH−1; one slot is reserved for the NOP.
  - Accept happens when req_valid & req_ready.
  - A legal accepted op is encoded and written at the current address, then the counter increments.
  - An illegal op is consumed: no write, err_illegal set.
  - req_valid while count = DEPTH−1 (so req_ready = 0) sets err_overflow; nothing is written.
  - load_end → TERM.
- TERM
  - Writes 0x00000013 (addi x0,x0,0) at the current address, increments the counter → DONE.
- DONE
  - prog_len = counter.
  - core_start pulses in the cycle DONE is entered.
  - load_start → LOAD, which starts a new session at address 0.

Encoding (fields: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0]):
- R, opcode 0110011:
  - ADD f7=0000000 f3=000; SUB 0100000/000; AND 0000000/111; OR 0000000/110; SLL 0000000/001; SRA 0100000/101.
- ADDI, opcode 0010011, f3 000: imm[11:0] → [31:20].
- LW, opcode 0000011, f3 010: imm[11:0] → [31:20].
- SW, opcode 0100011, f3 010: imm[11:5] → [31:25], imm[4:0] → [11:7].
- BEQ, opcode 1100011, f3 000: imm[12|10:5] → [31:25], imm[4:1|11] → [11:7].
- MAC, opcode 1111111, f7 0000000, f3 000: R format.
- Fields unused by a format are taken from the request as-is. rd is ignored for SW and BEQ.

## Timing
- Reset values: state IDLE, req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, prog_len 0, core_start 0, both error flags 0.
- Write latency: accept in cycle N → imem_we/addr/wdata registered and valid in cycle N+1 for exactly one cycle. Throughput is one word per cycle.
- req_ready is a registered function of state and count; it never depends combinationally on req_valid.
- load_end in the same cycle as an accept: the request is encoded first, and the NOP follows one cycle later at the next address.
- load_start outside IDLE/DONE is ignored.
- load_end outside LOAD is ignored.
- rst mid-session: IDLE on the next edge. Memory contents already written are left unchanged; no NOP, no core_start.
- The address never wraps. The NOP is always written at an address ≤ DEPTH−1.

## Structure
- Shared package holds:
  - the op enum;
  - opcode constants R/I/L/S/B/MAC (0110011, 0010011, 0000011, 0100011, 1100011, 1111111);
  - funct3/funct7 constants;
  - NOP constant 0x00000013.
- Sub-module instr_encode: purely combinational (op, rd, rs1, rs2, imm) → (word, illegal).
- The top level holds the FSM, counter and output registers.

## Test plan
- ADD rd=3 rs1=1 rs2=2 → imem_wdata 0x002081B3 at addr 0.
- SUB rd=5 rs1=6 rs2=7 → 0x407302B3.
- ADDI rd=1 rs1=0 imm=5 → 0x00500093.
- Check each legal op, all at consecutive addresses:
  - SW rs1=1 rs2=2 imm=8 → 0x0020A423;
  - BEQ rs1=1 rs2=2 imm=8 → 0x00208463;
  - MAC rd=4 rs1=1 rs2=2 → 0x0020827F.
- Two ops then load_end: 0x00000013 written at addr 2, prog_len=3, core_start high for one cycle.
- req_op=12 → no write, err_illegal=1, the next legal op lands at the unchanged address.
- DEPTH=4 with 4 requests held valid:
  - the first 3 are written;
  - req_ready drops and err_overflow sets;
  - load_end → NOP at addr 3, prog_len=4.
- rst asserted after two writes → IDLE next cycle, all outputs at reset values, core_start never pulses.
